// File: rtl/mem_fill_ctrl.sv
// Memory-side controller for the write-back data cache: assembles missed lines
// from DRAM beats for the fill port and forwards writeback beats to DRAM.
module mem_fill_ctrl #(
  parameter int LOG2CACHELINESIZE = 9,
  parameter int LOG2DRAMWIDTHBITS = 7
) (
  input  logic                                mem_clk,
  input  logic                                resetn,
  input  logic                                miss_req,
  input  logic [31:0]                         miss_addr,
  output logic                                miss_ack,
  output logic [31:0]                         mem_filladdr,
  output logic [(2**LOG2CACHELINESIZE)-1:0]   mem_filldata,
  output logic                                mem_fillrddirty,
  output logic                                mem_fillwe,
  input  logic [31:0]                         mem_wbaddr,
  input  logic [(2**LOG2DRAMWIDTHBITS)-1:0]   mem_wbdata,
  input  logic                                mem_wbwe,
  output logic                                mem_wback,
  output logic [31:0]                         dram_address,
  output logic                                dram_read,
  output logic                                dram_write,
  output logic [(2**LOG2DRAMWIDTHBITS)-1:0]   dram_writedata,
  input  logic                                dram_waitrequest,
  input  logic [(2**LOG2DRAMWIDTHBITS)-1:0]   dram_readdata,
  input  logic                                dram_readvalid
);

  localparam int CACHELINESIZE = 2**LOG2CACHELINESIZE;
  localparam int DRAMWIDTHBITS = 2**LOG2DRAMWIDTHBITS;
  localparam int BEATS         = CACHELINESIZE / DRAMWIDTHBITS;
  localparam int CW            = $clog2(BEATS) + 1;
  localparam int OFFS_BITS     = LOG2CACHELINESIZE - 3;
  localparam int BEAT_SHIFT    = LOG2DRAMWIDTHBITS - 3;
  localparam logic [31:0] LINE_MASK = ~((32'd1 << OFFS_BITS) - 32'd1);

  typedef enum logic [2:0] {
    IDLE,
    WB,
    RD_ISSUE,
    RD_WAIT,
    NOTIFY,
    FILL
  } state_t;

  state_t                   state_q;
  logic [CW-1:0]            issue_cnt_q;
  logic [CW-1:0]            recv_cnt_q;
  logic [CW-1:0]            recv_cnt_d;
  logic [31:0]              line_base_q;
  logic [CACHELINESIZE-1:0] line_q;
  logic                     miss_ack_q;
  logic                     rd_accept;
  logic                     beat_in;
  logic                     last_issue;
  logic [31:0]              issue_off;

  assign rd_accept  = (state_q == RD_ISSUE) && !dram_waitrequest;
  assign beat_in    = dram_readvalid && ((state_q == RD_ISSUE) || (state_q == RD_WAIT));
  assign recv_cnt_d = recv_cnt_q + CW'(beat_in);
  assign last_issue = (issue_cnt_q == CW'(BEATS - 1));
  assign issue_off  = 32'(issue_cnt_q) << BEAT_SHIFT;

  always_ff @(posedge mem_clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= IDLE;
      issue_cnt_q <= '0;
      recv_cnt_q  <= '0;
      line_base_q <= '0;
      line_q      <= '0;
      miss_ack_q  <= 1'b0;
    end else begin
      miss_ack_q <= 1'b0;

      if (beat_in) begin
        for (int unsigned b = 0; b < BEATS; b++) begin
          if (recv_cnt_q == CW'(b)) begin
            line_q[b*DRAMWIDTHBITS +: DRAMWIDTHBITS] <= dram_readdata;
          end
        end
        recv_cnt_q <= recv_cnt_d;
      end

      case (state_q)
        IDLE: begin
          if (mem_wbwe) begin
            state_q <= WB;
          end else if (miss_req) begin
            state_q     <= RD_ISSUE;
            line_base_q <= miss_addr & LINE_MASK;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
            miss_ack_q  <= 1'b1;
          end
        end
        WB: begin
          if (!dram_waitrequest) state_q <= IDLE;
        end
        RD_ISSUE: begin
          if (rd_accept) issue_cnt_q <= issue_cnt_q + CW'(1);
          // Line completion wins over the issue bookkeeping in the same cycle.
          if (recv_cnt_d == CW'(BEATS)) begin
            state_q <= NOTIFY;
          end else if (rd_accept && last_issue) begin
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (recv_cnt_d == CW'(BEATS)) state_q <= NOTIFY;
        end
        NOTIFY:  state_q <= FILL;
        FILL:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    dram_read      = 1'b0;
    dram_write     = 1'b0;
    dram_address   = '0;
    dram_writedata = '0;
    if (state_q == WB) begin
      dram_write     = 1'b1;
      dram_address   = mem_wbaddr;
      dram_writedata = mem_wbdata;
    end else if (state_q == RD_ISSUE) begin
      dram_read    = 1'b1;
      dram_address = line_base_q + issue_off;
    end
  end

  // Ack is combinational so the writeback buffer advances on the accepting edge.
  assign mem_wback       = (state_q == WB) && !dram_waitrequest;
  assign miss_ack        = miss_ack_q;
  assign mem_fillrddirty = (state_q == NOTIFY);
  assign mem_fillwe      = (state_q == FILL);
  assign mem_filladdr    = line_base_q;
  assign mem_filldata    = line_q;

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Randomized self-checking bench for mem_fill_ctrl with a behavioural DRAM
// and cache-side requester; a second instance covers the one-beat line case.
module tb_mem_fill_ctrl;

  localparam int LINE_BITS  = 512;
  localparam int LINE_BYTES = 64;
  localparam int NBEATS     = 4;
  localparam int BEAT_BYTES = 16;

  logic         mem_clk;
  logic         resetn;
  logic         miss_req;
  logic [31:0]  miss_addr;
  logic         miss_ack;
  logic [31:0]  mem_filladdr;
  logic [511:0] mem_filldata;
  logic         mem_fillrddirty;
  logic         mem_fillwe;
  logic [31:0]  mem_wbaddr;
  logic [127:0] mem_wbdata;
  logic         mem_wbwe;
  logic         mem_wback;
  logic [31:0]  dram_address;
  logic         dram_read;
  logic         dram_write;
  logic [127:0] dram_writedata;
  logic         dram_waitrequest;
  logic [127:0] dram_readdata;
  logic         dram_readvalid;

  logic         b1_miss_req;
  logic [31:0]  b1_miss_addr;
  logic         b1_miss_ack;
  logic [31:0]  b1_filladdr;
  logic [127:0] b1_filldata;
  logic         b1_fillrddirty;
  logic         b1_fillwe;
  logic         b1_wback;
  logic [31:0]  b1_dram_address;
  logic         b1_dram_read;
  logic         b1_dram_write;
  logic [127:0] b1_dram_writedata;
  logic         b1_readvalid;
  logic [127:0] b1_readdata;

  mem_fill_ctrl u_dut (
    .mem_clk          (mem_clk),
    .resetn           (resetn),
    .miss_req         (miss_req),
    .miss_addr        (miss_addr),
    .miss_ack         (miss_ack),
    .mem_filladdr     (mem_filladdr),
    .mem_filldata     (mem_filldata),
    .mem_fillrddirty  (mem_fillrddirty),
    .mem_fillwe       (mem_fillwe),
    .mem_wbaddr       (mem_wbaddr),
    .mem_wbdata       (mem_wbdata),
    .mem_wbwe         (mem_wbwe),
    .mem_wback        (mem_wback),
    .dram_address     (dram_address),
    .dram_read        (dram_read),
    .dram_write       (dram_write),
    .dram_writedata   (dram_writedata),
    .dram_waitrequest (dram_waitrequest),
    .dram_readdata    (dram_readdata),
    .dram_readvalid   (dram_readvalid)
  );

  mem_fill_ctrl #(.LOG2CACHELINESIZE(7), .LOG2DRAMWIDTHBITS(7)) u_dut_b1 (
    .mem_clk          (mem_clk),
    .resetn           (resetn),
    .miss_req         (b1_miss_req),
    .miss_addr        (b1_miss_addr),
    .miss_ack         (b1_miss_ack),
    .mem_filladdr     (b1_filladdr),
    .mem_filldata     (b1_filldata),
    .mem_fillrddirty  (b1_fillrddirty),
    .mem_fillwe       (b1_fillwe),
    .mem_wbaddr       (32'h0),
    .mem_wbdata       (128'h0),
    .mem_wbwe         (1'b0),
    .mem_wback        (b1_wback),
    .dram_address     (b1_dram_address),
    .dram_read        (b1_dram_read),
    .dram_write       (b1_dram_write),
    .dram_writedata   (b1_dram_writedata),
    .dram_waitrequest (1'b0),
    .dram_readdata    (b1_readdata),
    .dram_readvalid   (b1_readvalid)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // DRAM contents: lazily randomised, updated by accepted writebacks.
  logic [127:0] mem [logic [31:0]];

  function automatic logic [127:0] memval(input logic [31:0] a);
    if (!mem.exists(a)) mem[a] = {$urandom(), $urandom(), $urandom(), $urandom()};
    return mem[a];
  endfunction

  function automatic logic [511:0] exp_line(input logic [31:0] base);
    logic [511:0] l;
    for (int i = 0; i < NBEATS; i++) l[i*128 +: 128] = memval(base + 32'(i * BEAT_BYTES));
    return l;
  endfunction

  // Requester / DRAM environment state
  bit           miss_pend, wb_pend, fill_exp;
  logic [31:0]  m_addr, w_addr, exp_base, fa_seen;
  logic [127:0] w_data;
  int           stall_left, stall_pct;
  int           lat_list[$];
  int           due_q[$];
  logic [127:0] dat_q[$];
  int           last_due;

  int ack_cyc, n_ack, wback_cyc, n_wback, rd_cyc, n_rd, we_cyc, n_we;
  int first_rd, last_rd, n_issued, n_wr, beats_sent, last_beat;

  task automatic launch_miss(input logic [31:0] a);
    m_addr    = a;
    exp_base  = a - (a % LINE_BYTES);
    miss_pend = 1;
  endtask

  task automatic run(input int budget, input int abort_beats);
    bit done;
    int lat, due;
    ack_cyc = -1; n_ack = 0; wback_cyc = -1; n_wback = 0;
    rd_cyc = -1; n_rd = 0; we_cyc = -1; n_we = 0;
    first_rd = -1; last_rd = -1; n_issued = 0; n_wr = 0;
    beats_sent = 0; last_beat = -1; last_due = -1;
    fill_exp = miss_pend;
    done = 0;
    for (int t = 0; !done; t++) begin
      if (t >= budget) begin
        chk("run_timeout", 512'(t), 512'(budget - 1));
        done = 1;
      end else begin
        @(negedge mem_clk);
        miss_req   = miss_pend;
        miss_addr  = m_addr;
        mem_wbwe   = wb_pend;
        mem_wbaddr = w_addr;
        mem_wbdata = w_data;
        if (due_q.size() > 0 && due_q[0] <= t) begin
          dram_readvalid = 1'b1;
          dram_readdata  = dat_q.pop_front();
          void'(due_q.pop_front());
          beats_sent++;
          last_beat = t;
        end else begin
          dram_readvalid = 1'b0;
          dram_readdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
        end
        #1;
        if ((dram_read || dram_write) && stall_left > 0) begin
          dram_waitrequest = 1'b1;
          stall_left--;
        end else if (dram_read || dram_write) begin
          dram_waitrequest = ($urandom_range(0, 99) < 32'(stall_pct));
        end else begin
          dram_waitrequest = 1'($urandom_range(0, 1));
        end
        #1;
        if (dram_read || dram_write) chk("rd_wr_exclusive", dram_read & dram_write, 0);
        if (miss_ack) begin
          n_ack++;
          ack_cyc = t;
          chk("ack_while_wb_pending", wb_pend, 0);
          miss_pend = 0;
        end
        if (dram_write) begin
          n_wr++;
          chk("wr_addr", dram_address, w_addr);
          chk("wr_data", dram_writedata, w_data);
        end
        if (mem_wback) begin
          n_wback++;
          wback_cyc = t;
          chk("wback_with_write", dram_write, 1);
          mem[w_addr] = w_data;
          wb_pend = 0;
        end
        if (dram_read && !dram_waitrequest) begin
          chk("rd_addr", dram_address, exp_base + 32'(n_issued * BEAT_BYTES));
          if (lat_list.size() > 0) lat = lat_list.pop_front();
          else lat = $urandom_range(1, 6);
          due = t + lat;
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          due_q.push_back(due);
          dat_q.push_back(memval(dram_address));
          if (first_rd < 0) first_rd = t;
          last_rd = t;
          n_issued++;
        end
        if (mem_fillrddirty) begin
          n_rd++;
          rd_cyc = t;
          chk("notify_addr", mem_filladdr, exp_base);
          chk("notify_data", mem_filldata, exp_line(exp_base));
        end
        if (mem_fillwe) begin
          n_we++;
          we_cyc  = t;
          fa_seen = mem_filladdr;
          chk("fill_addr", mem_filladdr, exp_base);
          chk("fill_data", mem_filldata, exp_line(exp_base));
        end
        if (abort_beats > 0 && beats_sent >= abort_beats) done = 1;
        else if (!miss_pend && !wb_pend && due_q.size() == 0 &&
                 (!fill_exp || (n_we > 0 && t > we_cyc))) done = 1;
      end
    end
  endtask

  task automatic check_fill();
    chk("n_ack", n_ack, 1);
    chk("n_reads", n_issued, NBEATS);
    chk("n_rddirty", n_rd, 1);
    chk("n_fillwe", n_we, 1);
    chk("rddirty_after_last_beat", rd_cyc, last_beat + 1);
    chk("fillwe_after_rddirty", we_cyc, rd_cyc + 1);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_miss_ack"}, miss_ack, 0);
    chk({tag, "_filladdr"}, mem_filladdr, 0);
    chk({tag, "_filldata"}, mem_filldata, 0);
    chk({tag, "_rddirty"}, mem_fillrddirty, 0);
    chk({tag, "_fillwe"}, mem_fillwe, 0);
    chk({tag, "_wback"}, mem_wback, 0);
    chk({tag, "_dram_addr"}, dram_address, 0);
    chk({tag, "_dram_read"}, dram_read, 0);
    chk({tag, "_dram_write"}, dram_write, 0);
    chk({tag, "_dram_wdata"}, dram_writedata, 0);
  endtask

  int b1_ack, b1_acc, b1_rd, b1_we, b1_nrd;
  logic [127:0] b1_beat;
  logic [31:0]  b1_a;

  initial begin
    resetn = 1'b0;
    miss_req = 0; miss_addr = 0; mem_wbwe = 0; mem_wbaddr = 0; mem_wbdata = 0;
    dram_waitrequest = 0; dram_readdata = 0; dram_readvalid = 0;
    b1_miss_req = 0; b1_miss_addr = 0; b1_readvalid = 0; b1_readdata = 0;
    miss_pend = 0; wb_pend = 0; stall_left = 0; stall_pct = 0;
    m_addr = 0; w_addr = 0; w_data = 0; exp_base = 0; fa_seen = 0;

    repeat (2) @(negedge mem_clk);
    #1;
    check_idle_outputs("reset");
    chk("b1_reset_filldata", b1_filldata, 0);
    chk("b1_reset_read", b1_dram_read, 0);
    @(negedge mem_clk);
    resetn = 1'b1;

    // Directed miss at 0x1234, L=1, no stalls
    lat_list = '{1, 1, 1, 1};
    launch_miss(32'h0000_1234);
    run(60, 0);
    check_fill();
    chk("d1_ack_cyc", ack_cyc, 1);
    chk("d1_first_rd", first_rd, 1);
    chk("d1_last_rd", last_rd, 4);
    chk("d1_rddirty_cyc", rd_cyc, 6);
    chk("d1_fillwe_cyc", we_cyc, 7);
    chk("d1_filladdr", fa_seen, 32'h1200);

    // Writeback stalled for 3 cycles
    w_addr = 32'h4000;
    w_data = {4{32'hDEAD_BEEF}};
    wb_pend = 1;
    stall_left = 3;
    run(60, 0);
    chk("wb_write_cycles", n_wr, 4);
    chk("wb_ack_cyc", wback_cyc, 4);
    chk("wb_n_ack", n_wback, 1);

    // Simultaneous writeback and miss
    w_addr = 32'h0000_8000;
    w_data = {$urandom(), $urandom(), $urandom(), $urandom()};
    wb_pend = 1;
    launch_miss(32'h0000_8040);
    run(80, 0);
    check_fill();
    chk("both_wback_cyc", wback_cyc, 1);
    chk("both_ack_gap", ack_cyc - wback_cyc, 2);

    // Variable latency overlapping issue
    lat_list = '{1, 5, 2, 3};
    launch_miss(32'h0001_0000 | 32'($urandom_range(0, 63)));
    run(80, 0);
    check_fill();
    chk("varlat_rddirty_cyc", rd_cyc, 10);

    // Reset after two beats received
    lat_list = '{1, 1, 4, 4};
    launch_miss(32'h0002_0080);
    run(80, 2);
    @(negedge mem_clk);
    resetn = 1'b0;
    miss_pend = 0; miss_req = 0; mem_wbwe = 0;
    dram_readvalid = 0; dram_waitrequest = 0;
    #1;
    check_idle_outputs("midreset");
    @(negedge mem_clk);
    resetn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      dram_readvalid = 1'b1;
      dram_readdata  = {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      chk("stray_no_ack", miss_ack, 0);
      chk("stray_no_rddirty", mem_fillrddirty, 0);
      chk("stray_no_fillwe", mem_fillwe, 0);
      chk("stray_no_read", dram_read, 0);
      chk("stray_line_clear", mem_filldata, 0);
      @(negedge mem_clk);
    end
    dram_readvalid = 1'b0;
    due_q.delete(); dat_q.delete(); lat_list.delete();
    launch_miss(32'h0002_00C0);
    run(80, 0);
    check_fill();

    // Randomized mix
    for (int it = 0; it < 40; it++) begin
      int kind;
      kind = $urandom_range(0, 2);
      stall_pct = $urandom_range(0, 40);
      if (kind != 0) begin
        w_addr  = ($urandom_range(0, 1) ? $urandom() : ($urandom() & 32'h0000_0FFF)) & ~32'hF;
        w_data  = {$urandom(), $urandom(), $urandom(), $urandom()};
        wb_pend = 1;
      end
      if (kind != 1) launch_miss($urandom_range(0, 1) ? $urandom() : ($urandom() & 32'h0000_0FFF));
      run(300, 0);
      if (kind != 1) check_fill();
      else chk("rand_wb_no_read", n_issued, 0);
      if (kind != 0) chk("rand_n_wback", n_wback, 1);
      if (kind == 2) chk("rand_wb_before_ack", ack_cyc > wback_cyc, 1);
    end
    stall_pct = 0;

    // One-beat line instance
    b1_a = $urandom();
    b1_beat = {$urandom(), $urandom(), $urandom(), $urandom()};
    b1_ack = -1; b1_acc = -10; b1_rd = -1; b1_we = -1; b1_nrd = 0;
    for (int t = 0; t < 12; t++) begin
      @(negedge mem_clk);
      b1_miss_req  = (b1_ack < 0);
      b1_miss_addr = b1_a;
      b1_readvalid = (t == b1_acc + 1);
      b1_readdata  = (t == b1_acc + 1) ? b1_beat : {$urandom(), $urandom(), $urandom(), $urandom()};
      #1;
      if (b1_miss_ack) b1_ack = t;
      if (b1_dram_read) begin
        b1_nrd++;
        b1_acc = t;
        chk("b1_rd_addr", b1_dram_address, b1_a - (b1_a % 16));
      end
      if (b1_fillrddirty) b1_rd = t;
      if (b1_fillwe) begin
        b1_we = t;
        chk("b1_fill_data", b1_filldata, b1_beat);
        chk("b1_fill_addr", b1_filladdr, b1_a - (b1_a % 16));
      end
    end
    b1_miss_req = 0;
    b1_readvalid = 0;
    chk("b1_ack_cyc", b1_ack, 1);
    chk("b1_n_reads", b1_nrd, 1);
    chk("b1_rddirty_cyc", b1_rd, 3);
    chk("b1_fillwe_cyc", b1_we, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
